ime_sad_buf_ctrl: RTL

IME_SAD_BUF_CTRL -- requirements
Module: ime_sad_buf_ctrl

---
 rtl/ime_sad_buf_ctrl_pkg.sv | 16 +
 rtl/ime_sad_buf_ctrl_if.sv | 29 ++
 rtl/ime_sad_buf_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/ime_sad_buf_ctrl_pkg.sv
// Shared IME constants for the SAD buffer controller: buffer geometry and
// the legacy state encoding.
package ime_sad_buf_ctrl_pkg;

  localparam int unsigned IME_DEPTH   = 32;
  localparam int unsigned IME_NUM_BLK = 3;
  localparam int unsigned IME_ADDR_W  = 5;
  localparam int unsigned IME_BLK_W   = 2;

  typedef logic [1:0] ime_state_t;

  localparam ime_state_t ST_IDLE = 2'd0;
  localparam ime_state_t ST_FILL = 2'd1;
  localparam ime_state_t ST_FULL = 2'd2;

endpackage

// File: rtl/ime_sad_buf_ctrl_if.sv
// Control bundle between the SAD datapath/consumer and the buffer controller.
interface ime_sad_buf_ctrl_if;
  import ime_sad_buf_ctrl_pkg::*;

  logic                     start_i;
  logic                     sad_vld_i;
  logic                     rd_req_i;
  logic [IME_ADDR_W-1:0]    rd_addr_i;
  logic                     release_i;
  logic [IME_ADDR_W-1:0]    addr_o;
  logic                     wren_o;
  logic [IME_BLK_W-1:0]     block_o;
  logic                     rd_gnt_o;
  logic                     rd_vld_o;
  logic [IME_NUM_BLK-1:0]   filled_o;
  logic                     done_o;
  logic                     err_o;

  modport master (
    output start_i, sad_vld_i, rd_req_i, rd_addr_i, release_i,
    input  addr_o, wren_o, block_o, rd_gnt_o, rd_vld_o, filled_o, done_o, err_o
  );

  modport slave (
    input  start_i, sad_vld_i, rd_req_i, rd_addr_i, release_i,
    output addr_o, wren_o, block_o, rd_gnt_o, rd_vld_o, filled_o, done_o, err_o
  );

endinterface

// File: rtl/ime_sad_buf_ctrl.sv
// SAD buffer controller: sequences SAD rows into NUM_BLK buffers of DEPTH
// entries, arbitrates consumer reads (writes win) and flags stray SAD rows.
module ime_sad_buf_ctrl
  import ime_sad_buf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = IME_DEPTH,
  parameter int unsigned NUM_BLK = IME_NUM_BLK
) (
  input  logic                  clk,
  input  logic                  rst,
  ime_sad_buf_ctrl_if.slave     bus
);

  ime_state_t               state;
  logic [IME_ADDR_W-1:0]    wr_cnt;
  logic [IME_BLK_W-1:0]     blk_cnt;
  logic [IME_NUM_BLK-1:0]   filled_q;
  logic [IME_ADDR_W-1:0]    addr_q;
  logic                     rd_vld_q;
  logic                     err_q;

  logic                     wren;
  logic                     rd_gnt;
  logic                     wrap;
  logic                     last_wr;
  logic [IME_ADDR_W-1:0]    addr;

  // Write/read arbitration and the address mux; addr holds when idle.
  always_comb begin
    wren    = bus.sad_vld_i & (state == ST_FILL);
    rd_gnt  = bus.rd_req_i & ~wren & (state != ST_IDLE);
    wrap    = wren & (wr_cnt == IME_ADDR_W'(DEPTH - 1));
    last_wr = wrap & (blk_cnt == IME_BLK_W'(NUM_BLK - 1));
    addr    = addr_q;
    if (wren) begin
      addr = wr_cnt;
    end else if (rd_gnt) begin
      addr = bus.rd_addr_i;
    end
  end

  // FSM and write/block counters; start_i overrides everything but rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_cnt   <= '0;
      blk_cnt  <= '0;
      filled_q <= '0;
    end else if (bus.start_i) begin
      state    <= ST_FILL;
      wr_cnt   <= '0;
      blk_cnt  <= '0;
      filled_q <= '0;
    end else begin
      if (wren) begin
        wr_cnt <= wrap ? '0 : wr_cnt + 1'b1;
        if (wrap) begin
          // block counter parks at 0 after the last buffer so it never leaves range
          blk_cnt <= last_wr ? '0 : blk_cnt + 1'b1;
          for (int unsigned k = 0; k < NUM_BLK; k++) begin
            if (blk_cnt == IME_BLK_W'(k)) filled_q[k] <= 1'b1;
          end
        end
      end
      case (state)
        ST_FILL: if (last_wr) state <= ST_FULL;
        ST_FULL: if (bus.release_i) state <= ST_IDLE;
        default: state <= state;
      endcase
    end
  end

  // Held address, one-cycle read latency and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr;
      rd_vld_q <= rd_gnt;
      if (bus.sad_vld_i && state != ST_FILL) err_q <= 1'b1;
    end
  end

  assign bus.addr_o   = addr;
  assign bus.wren_o   = wren;
  assign bus.block_o  = blk_cnt;
  assign bus.rd_gnt_o = rd_gnt;
  assign bus.rd_vld_o = rd_vld_q;
  assign bus.filled_o = filled_q;
  assign bus.done_o   = (state == ST_FULL);
  assign bus.err_o    = err_q;

endmodule
